// File: rtl/load_scoreboard_if.sv
// Handshake and status bundle between the memory stage / decode and the load scoreboard.
// The core side drives issue/response/decode sources; the scoreboard returns stall and status.
interface load_scoreboard_if #(
  parameter int unsigned DEPTH = 4
) ();
  logic                     issue_valid;
  logic [4:0]               issue_rd;
  logic                     resp_valid;
  logic [4:0]               Rs1D;
  logic [4:0]               Rs2D;
  logic                     StallLdD;
  logic                     full;
  logic [4:0]               wb_rd;
  logic [31:0]              busy;
  logic [$clog2(DEPTH):0]   pending;
  logic                     err_overflow;
  logic                     err_underflow;

  modport master (
    output issue_valid, issue_rd, resp_valid, Rs1D, Rs2D,
    input  StallLdD, full, wb_rd, busy, pending, err_overflow, err_underflow
  );

  modport slave (
    input  issue_valid, issue_rd, resp_valid, Rs1D, Rs2D,
    output StallLdD, full, wb_rd, busy, pending, err_overflow, err_underflow
  );
endinterface

// File: rtl/load_scoreboard.sv
// Tracks destination registers of outstanding variable-latency loads and raises a decode
// stall while any source register still waits on one; loads retire in issue order.
module load_scoreboard #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 2
) (
  input logic              clk,
  input logic              reset,
  load_scoreboard_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [AW:0] DepthW = DEPTH[AW:0];

  logic [4:0]       fifo_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic             err_ovf_q, err_udf_q;

  logic        empty, full, pop, push, issue_nz, sat;
  logic [4:0]  head;
  logic [AW:0] occ;
  logic [31:0] busy;
  logic        hit1, hit2;

  // Extra wrap bit on the pointers separates full from empty.
  assign occ      = wr_q - rd_q;
  assign empty    = (wr_q == rd_q);
  assign full     = (occ == DepthW);
  assign head     = fifo_q[rd_q[AW-1:0]];
  assign pop      = bus.resp_valid & ~empty;
  assign issue_nz = bus.issue_valid & (bus.issue_rd != 5'd0);
  assign sat      = (cnt_q[bus.issue_rd] == CntMax);
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign push     = issue_nz & ~sat & (~full | pop);

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (push && bus.issue_rd == 5'(i)) cnt_d[i] = cnt_d[i] + CNT_W'(1);
      if (pop && head == 5'(i))          cnt_d[i] = cnt_d[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_q[AW-1:0]] <= bus.issue_rd;
        wr_q                 <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      if (issue_nz && !push)             err_ovf_q <= 1'b1;
      if (bus.resp_valid && empty)       err_udf_q <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 1; i < 32; i++) busy[i] = (cnt_q[i] != '0);
  end

  // busy is registered, so a completing response keeps the stall for its own cycle.
  assign hit1 = (bus.Rs1D != 5'd0) &
                (busy[bus.Rs1D] | (bus.issue_valid & (bus.issue_rd == bus.Rs1D)));
  assign hit2 = (bus.Rs2D != 5'd0) &
                (busy[bus.Rs2D] | (bus.issue_valid & (bus.issue_rd == bus.Rs2D)));

  assign bus.StallLdD      = hit1 | hit2;
  assign bus.full          = full;
  assign bus.wb_rd         = pop ? head : 5'd0;
  assign bus.busy          = busy;
  assign bus.pending       = occ;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.err_underflow = err_udf_q;
endmodule

// File: tb/tb_load_scoreboard.sv
// Directed bench for load_scoreboard: issue/response ordering, stall timing, full and
// saturation boundaries, underflow and asynchronous reset.
module tb_load_scoreboard;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  load_scoreboard_if #(.DEPTH(4)) sb ();

  load_scoreboard #(.DEPTH(4), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    sb.issue_valid = 1'b1;
    sb.issue_rd    = rd;
    tick();
    sb.issue_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sb.issue_valid = 1'b0;
    sb.issue_rd    = 5'd0;
    sb.resp_valid  = 1'b0;
    sb.Rs1D        = 5'd0;
    sb.Rs2D        = 5'd0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Idle after reset
    sb.Rs1D = 5'd5;
    #1;
    chk("rst_busy", sb.busy, 32'h0);
    chk("rst_pending", 32'(sb.pending), 32'd0);
    chk("rst_full", 32'(sb.full), 32'd0);
    chk("rst_stall", 32'(sb.StallLdD), 32'd0);
    chk("rst_wb_rd", 32'(sb.wb_rd), 32'd0);
    chk("rst_errs", {30'd0, sb.err_overflow, sb.err_underflow}, 32'd0);

    // Same-cycle issue coverage, then response holds the stall one more cycle
    sb.issue_valid = 1'b1;
    sb.issue_rd    = 5'd5;
    #1;
    chk("issue_same_cycle_stall", 32'(sb.StallLdD), 32'd1);
    tick();
    sb.issue_valid = 1'b0;
    #1;
    chk("busy5", sb.busy, 32'h20);
    chk("pending1", 32'(sb.pending), 32'd1);
    sb.resp_valid = 1'b1;
    #1;
    chk("wb_rd5", 32'(sb.wb_rd), 32'd5);
    chk("stall_during_resp", 32'(sb.StallLdD), 32'd1);
    tick();
    sb.resp_valid = 1'b0;
    #1;
    chk("busy5_clear", sb.busy, 32'h0);
    chk("stall_released", 32'(sb.StallLdD), 32'd0);
    sb.Rs1D = 5'd0;

    // Fill with 3,7,3,9 and drain in order
    issue(5'd3);
    issue(5'd7);
    issue(5'd3);
    issue(5'd9);
    #1;
    chk("fill_full", 32'(sb.full), 32'd1);
    chk("fill_pending", 32'(sb.pending), 32'd4);
    chk("fill_busy", sb.busy, 32'h288);
    sb.resp_valid = 1'b1;
    #1;
    chk("pop1_rd", 32'(sb.wb_rd), 32'd3);
    tick();
    chk("pop2_rd", 32'(sb.wb_rd), 32'd7);
    chk("busy3_after_first", sb.busy, 32'h288);
    tick();
    chk("pop3_rd", 32'(sb.wb_rd), 32'd3);
    tick();
    chk("busy3_cleared", sb.busy, 32'h200);
    chk("pop4_rd", 32'(sb.wb_rd), 32'd9);
    tick();
    sb.resp_valid = 1'b0;
    #1;
    chk("drain_pending", 32'(sb.pending), 32'd0);
    chk("drain_busy", sb.busy, 32'h0);
    chk("drain_full", 32'(sb.full), 32'd0);

    // Full with concurrent pop accepts; full without pop rejects
    issue(5'd1);
    issue(5'd2);
    issue(5'd3);
    issue(5'd8);
    sb.issue_valid = 1'b1;
    sb.issue_rd    = 5'd4;
    sb.resp_valid  = 1'b1;
    #1;
    chk("full_pop_wb", 32'(sb.wb_rd), 32'd1);
    tick();
    sb.resp_valid = 1'b0;
    sb.issue_valid = 1'b0;
    #1;
    chk("full_pop_pending", 32'(sb.pending), 32'd4);
    chk("full_pop_no_ovf", 32'(sb.err_overflow), 32'd0);
    chk("full_pop_busy", sb.busy, 32'h11C);
    issue(5'd10);
    #1;
    chk("full_reject_ovf", 32'(sb.err_overflow), 32'd1);
    chk("full_reject_pending", 32'(sb.pending), 32'd4);
    chk("full_reject_busy", sb.busy, 32'h11C);
    sb.resp_valid = 1'b1;
    #1;
    chk("tail_pop_a", 32'(sb.wb_rd), 32'd2);
    tick();
    chk("tail_pop_b", 32'(sb.wb_rd), 32'd3);
    tick();
    chk("tail_pop_c", 32'(sb.wb_rd), 32'd8);
    tick();
    chk("tail_pop_d", 32'(sb.wb_rd), 32'd4);
    tick();
    sb.resp_valid = 1'b0;
    #1;
    chk("tail_empty", 32'(sb.pending), 32'd0);

    // x0 issue is a no-op; response while empty is an underflow
    sb.issue_valid = 1'b1;
    sb.issue_rd    = 5'd0;
    sb.Rs2D        = 5'd0;
    #1;
    chk("x0_no_stall", 32'(sb.StallLdD), 32'd0);
    tick();
    sb.issue_valid = 1'b0;
    #1;
    chk("x0_no_push", 32'(sb.pending), 32'd0);
    chk("x0_no_udf", 32'(sb.err_underflow), 32'd0);
    sb.resp_valid = 1'b1;
    #1;
    chk("udf_wb_rd", 32'(sb.wb_rd), 32'd0);
    tick();
    sb.resp_valid = 1'b0;
    #1;
    chk("udf_set", 32'(sb.err_underflow), 32'd1);
    chk("ovf_sticky", 32'(sb.err_overflow), 32'd1);

    // Two loads to x6, then asynchronous reset between clock edges
    issue(5'd6);
    issue(5'd6);
    #1;
    chk("x6_busy", sb.busy, 32'h40);
    chk("x6_pending", 32'(sb.pending), 32'd2);
    reset = 1'b1;
    #1;
    chk("async_busy", sb.busy, 32'h0);
    chk("async_pending", 32'(sb.pending), 32'd0);
    chk("async_errs", {30'd0, sb.err_overflow, sb.err_underflow}, 32'd0);
    reset = 1'b0;
    sb.resp_valid = 1'b1;
    tick();
    sb.resp_valid = 1'b0;
    #1;
    chk("post_rst_udf", 32'(sb.err_underflow), 32'd1);

    // Counter saturation: fourth load to x11 is rejected
    issue(5'd11);
    issue(5'd11);
    issue(5'd11);
    #1;
    chk("sat_no_ovf_yet", 32'(sb.err_overflow), 32'd0);
    chk("sat_pending3", 32'(sb.pending), 32'd3);
    issue(5'd11);
    #1;
    chk("sat_ovf", 32'(sb.err_overflow), 32'd1);
    chk("sat_pending_held", 32'(sb.pending), 32'd3);
    chk("sat_not_full", 32'(sb.full), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
